// File: rtl/imm_decode_stage_pkg.sv
// Shared definitions for the immediate decode stage.
//   extop_e       : immediate format select encodings, 110 is reserved
//   xlen_is_legal : datapath width legality check used at elaboration
package imm_decode_stage_pkg;

  localparam int EXTOP_W = 3;

  typedef enum logic [EXTOP_W-1:0] {
    EXT_I   = 3'b000,
    EXT_S   = 3'b001,
    EXT_B   = 3'b010,
    EXT_Z   = 3'b011,
    EXT_U   = 3'b100,
    EXT_SH  = 3'b101,
    EXT_RSV = 3'b110,
    EXT_J   = 3'b111
  } extop_e;

  function automatic bit xlen_is_legal(input int unsigned xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/imm_decode_stage_if.sv
// Request/response bus of the immediate decode stage.
//   in_*  : upstream request (valid/ready, instruction, format select, pc)
//   out_* : downstream result (valid/ready, immediate, branch target, error)
// slave  : the decode stage
// master : the environment driving requests and consuming results
interface imm_decode_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [2:0]      in_extop;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [XLEN-1:0] out_target;
  logic            out_err;

  modport slave (
    input  in_valid, in_inst, in_extop, in_pc, out_ready,
    output in_ready, out_valid, out_imm, out_target, out_err
  );

  modport master (
    output in_valid, in_inst, in_extop, in_pc, out_ready,
    input  in_ready, out_valid, out_imm, out_target, out_err
  );
endinterface

// File: rtl/imm_decode_stage_core.sv
// Combinational immediate generator.
//   inst  : instruction word, bits [6:0] unused
//   extop : immediate format select
//   imm   : sign/zero extended immediate, XLEN bits
//   err   : extop was the reserved code (imm forced to 0)
module imm_decode_core
  import imm_decode_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  input  extop_e          extop,
  output logic [XLEN-1:0] imm,
  output logic            err
);

  if (!xlen_is_legal(XLEN)) begin : g_bad_xlen
    $error("imm_decode_core: XLEN must be 32 or 64, got %0d", XLEN);
  end

  logic [31:0] imm32;
  logic        unused_opcode;

  assign unused_opcode = ^inst[6:0];

  always_comb begin
    imm32 = '0;
    err   = 1'b0;
    case (extop)
      EXT_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
      EXT_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      EXT_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      EXT_U:   imm32 = {inst[31:12], 12'b0};
      EXT_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      EXT_Z:   imm32 = {27'b0, inst[19:15]};
      EXT_SH:  imm32 = (XLEN == 64) ? {26'b0, inst[25:20]} : {27'b0, inst[24:20]};
      default: err   = 1'b1;
    endcase
  end

  // Zero-extended formats keep bit 31 clear, so one signed widening covers all formats.
  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_decode_stage.sv
// Immediate decode pipeline stage: decodes the immediate and branch target
// combinationally and registers them on acceptance (one cycle latency).
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset, priority over flush and transfers
//   flush : discards all buffered entries and the input of the same cycle
//   bus   : request/response bus (slave side)
// SKID_EN=1 adds a second entry so in_ready depends only on registered state.
module imm_decode_stage
  import imm_decode_stage_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SKID_EN = 1
) (
  input logic                clk,
  input logic                rst_n,
  input logic                flush,
  imm_decode_stage_if.slave  bus
);

  logic [XLEN-1:0] dec_imm;
  logic [XLEN-1:0] dec_target;
  logic            dec_err;

  logic            out_valid_q;
  logic [XLEN-1:0] out_imm_q;
  logic [XLEN-1:0] out_target_q;
  logic            out_err_q;

  logic            skid_valid_q;
  logic [XLEN-1:0] skid_imm_q;
  logic [XLEN-1:0] skid_target_q;
  logic            skid_err_q;

  logic            accept;
  logic            out_free;

  imm_decode_core #(.XLEN(XLEN)) u_core (
    .inst  (bus.in_inst),
    .extop (extop_e'(bus.in_extop)),
    .imm   (dec_imm),
    .err   (dec_err)
  );

  assign dec_target = bus.in_pc + dec_imm;

  assign bus.in_ready = rst_n &&
                        ((SKID_EN != 0) ? !skid_valid_q : (!out_valid_q || bus.out_ready));
  assign accept       = bus.in_valid && bus.in_ready && !flush;
  assign out_free     = !out_valid_q || bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      out_imm_q     <= '0;
      out_target_q  <= '0;
      out_err_q     <= 1'b0;
      skid_valid_q  <= 1'b0;
      skid_imm_q    <= '0;
      skid_target_q <= '0;
      skid_err_q    <= 1'b0;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (out_free) begin
      // A full skid entry blocks in_ready, so it always wins the output slot.
      if (skid_valid_q) begin
        out_valid_q  <= 1'b1;
        out_imm_q    <= skid_imm_q;
        out_target_q <= skid_target_q;
        out_err_q    <= skid_err_q;
        skid_valid_q <= 1'b0;
      end else begin
        out_valid_q <= accept;
        if (accept) begin
          out_imm_q    <= dec_imm;
          out_target_q <= dec_target;
          out_err_q    <= dec_err;
        end
      end
    end else if (accept) begin
      // Only reachable with SKID_EN=1: output stalled, park the new entry.
      skid_valid_q  <= 1'b1;
      skid_imm_q    <= dec_imm;
      skid_target_q <= dec_target;
      skid_err_q    <= dec_err;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_imm    = out_imm_q;
  assign bus.out_target = out_target_q;
  assign bus.out_err    = out_err_q;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage: a 32-bit skid instance and a 64-bit
// single-register instance sharing clock, reset and flush.
module tb_imm_decode_stage;

  logic clk;
  logic rst_n;
  logic flush;
  int   n_checks;
  int   n_errors;

  imm_decode_stage_if #(.XLEN(32)) ia ();
  imm_decode_stage_if #(.XLEN(64)) ib ();

  imm_decode_stage #(.XLEN(32), .SKID_EN(1)) u_dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (ia)
  );

  imm_decode_stage #(.XLEN(64), .SKID_EN(0)) u_dut64 (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (ib)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic [31:0] inst, input logic [2:0] extop, input logic [31:0] pc);
    ia.in_valid = 1'b1;
    ia.in_inst  = inst;
    ia.in_extop = extop;
    ia.in_pc    = pc;
  endtask

  // One request with out_ready=1; result must appear right after the accepting edge.
  task automatic xfer_a(input string tag, input logic [31:0] inst, input logic [2:0] extop,
                        input logic [31:0] pc, input logic [31:0] e_imm,
                        input logic [31:0] e_tgt, input logic e_err);
    drive_a(inst, extop, pc);
    ia.out_ready = 1'b1;
    step();
    ia.in_valid = 1'b0;
    chk({tag, ".valid"},  ia.out_valid,  1);
    chk({tag, ".imm"},    ia.out_imm,    e_imm);
    chk({tag, ".target"}, ia.out_target, e_tgt);
    chk({tag, ".err"},    ia.out_err,    e_err);
  endtask

  task automatic xfer_b(input string tag, input logic [31:0] inst, input logic [2:0] extop,
                        input logic [63:0] pc, input logic [63:0] e_imm,
                        input logic [63:0] e_tgt);
    ib.in_valid  = 1'b1;
    ib.in_inst   = inst;
    ib.in_extop  = extop;
    ib.in_pc     = pc;
    ib.out_ready = 1'b1;
    step();
    ib.in_valid = 1'b0;
    chk({tag, ".valid"},  ib.out_valid,  1);
    chk({tag, ".imm"},    ib.out_imm,    e_imm);
    chk({tag, ".target"}, ib.out_target, e_tgt);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    ia.in_valid = 1'b0; ia.in_inst = '0; ia.in_extop = '0; ia.in_pc = '0; ia.out_ready = 1'b0;
    ib.in_valid = 1'b0; ib.in_inst = '0; ib.in_extop = '0; ib.in_pc = '0; ib.out_ready = 1'b0;

    step();
    step();
    chk("rst.valid",  ia.out_valid,  0);
    chk("rst.imm",    ia.out_imm,    0);
    chk("rst.target", ia.out_target, 0);
    chk("rst.err",    ia.out_err,    0);
    chk("rst.ready",  ia.in_ready,   0);
    chk("rst.ready64", ib.in_ready,  0);
    rst_n = 1'b1;
    #1;
    chk("rel.ready", ia.in_ready, 1);

    // Single-format decode, XLEN=32
    xfer_a("i_neg", 32'hFFF00093, 3'b000, 32'h0,    32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    xfer_a("b_neg", 32'hFE000EE3, 3'b010, 32'h100,  32'hFFFFFFFC, 32'h000000FC, 0);
    xfer_a("u",     32'h123450B7, 3'b100, 32'h1000, 32'h12345000, 32'h12346000, 0);
    xfer_a("z",     32'h800F8073, 3'b011, 32'h0,    32'h0000001F, 32'h0000001F, 0);
    xfer_a("rsv",   32'hFFFFFFFF, 3'b110, 32'h2000, 32'h0,        32'h2000,     1);
    xfer_a("s_neg", 32'hFE000F23, 3'b001, 32'h10,   32'hFFFFFFFE, 32'h0000000E, 0);
    xfer_a("j_pos", 32'h0080006F, 3'b111, 32'h40,   32'h00000008, 32'h00000048, 0);
    xfer_a("j_neg", 32'hFFDFF06F, 3'b111, 32'h40,   32'hFFFFFFFC, 32'h0000003C, 0);
    xfer_a("sh32",  32'h02500013, 3'b101, 32'h0,    32'h00000005, 32'h00000005, 0);
    step();
    chk("drain.valid", ia.out_valid, 0);

    // Skid: A, B, C back-to-back with output stalled
    ia.out_ready = 1'b0;
    drive_a(32'h00100013, 3'b000, 32'h0);
    step();
    chk("skid.a_out",   ia.out_imm,  1);
    chk("skid.a_ready", ia.in_ready, 1);
    drive_a(32'h00200013, 3'b000, 32'h0);
    step();
    chk("skid.b_ready", ia.in_ready, 0);
    chk("skid.b_hold",  ia.out_imm,  1);
    drive_a(32'h00300013, 3'b000, 32'h0);
    step();
    chk("skid.c_held",  ia.in_ready, 0);
    chk("skid.stable",  ia.out_imm,  1);
    chk("skid.svalid",  ia.out_valid, 1);
    ia.out_ready = 1'b1;
    #1;
    chk("skid.no_comb", ia.in_ready, 0);
    step();
    chk("skid.b_out",   ia.out_imm,  2);
    chk("skid.b_valid", ia.out_valid, 1);
    chk("skid.c_ready", ia.in_ready, 1);
    step();
    ia.in_valid = 1'b0;
    chk("skid.c_out",   ia.out_imm,  3);
    chk("skid.c_valid", ia.out_valid, 1);
    step();
    chk("skid.empty",   ia.out_valid, 0);

    // Flush with two pending entries and a live input
    ia.out_ready = 1'b0;
    drive_a(32'h00100013, 3'b000, 32'h0);
    step();
    drive_a(32'h00200013, 3'b000, 32'h0);
    step();
    chk("fl.pending", ia.in_ready, 0);
    flush = 1'b1;
    ia.out_ready = 1'b1;
    drive_a(32'h00700013, 3'b000, 32'h0);
    step();
    flush = 1'b0;
    ia.in_valid = 1'b0;
    chk("fl.valid", ia.out_valid, 0);
    chk("fl.ready", ia.in_ready,  1);
    step();
    chk("fl.discard", ia.out_valid, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl.idle_ready", ia.in_ready, 1);
    chk("fl.idle_valid", ia.out_valid, 0);

    // Reset mid-stall
    ia.out_ready = 1'b0;
    drive_a(32'hFFF00093, 3'b000, 32'h300);
    step();
    drive_a(32'hFFF00093, 3'b110, 32'h300);
    step();
    ia.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst.ready_now", ia.in_ready, 0);
    step();
    chk("mrst.valid",  ia.out_valid,  0);
    chk("mrst.imm",    ia.out_imm,    0);
    chk("mrst.target", ia.out_target, 0);
    chk("mrst.err",    ia.out_err,    0);
    chk("mrst.ready",  ia.in_ready,   0);
    rst_n = 1'b1;
    #1;
    chk("mrst.rel_ready", ia.in_ready, 1);
    step();
    chk("mrst.after_valid", ia.out_valid, 0);

    // XLEN=64, single output register
    xfer_b("u64",  32'h800000B7, 3'b100, 64'h0,   64'hFFFFFFFF80000000, 64'hFFFFFFFF80000000);
    xfer_b("b64",  32'hFE000EE3, 3'b010, 64'h100, 64'hFFFFFFFFFFFFFFFC, 64'h00000000000000FC);
    xfer_b("sh64", 32'h02500013, 3'b101, 64'h8,   64'h25,               64'h2D);
    ib.out_ready = 1'b0;
    #1;
    chk("reg64.stall_ready", ib.in_ready, 0);
    ib.out_ready = 1'b1;
    #1;
    chk("reg64.drain_ready", ib.in_ready, 1);
    step();
    chk("reg64.empty", ib.out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
